// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-requester mux arbiter.
// Holds the requester count, select width, FSM state encoding and one-hot decode.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
    onehot = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/mux_4to1.sv
// Plain 4:1 data mux; lane i is d[i*DATA_W +: DATA_W].
module mux_4to1 #(
  parameter int DATA_W = 1
) (
  input  logic [4*DATA_W-1:0] d,
  input  logic [1:0]          sel,
  output logic [DATA_W-1:0]   q
);

  // Lane select.
  always_comb begin
    case (sel)
      2'd0:    q = d[0*DATA_W +: DATA_W];
      2'd1:    q = d[1*DATA_W +: DATA_W];
      2'd2:    q = d[2*DATA_W +: DATA_W];
      2'd3:    q = d[3*DATA_W +: DATA_W];
      default: q = d[0*DATA_W +: DATA_W];
    endcase
  end

endmodule

// File: rtl/mux_arb_pick.sv
// Combinational winner picker: lowest index in fixed mode, or the first
// requester after 'last' in round-robin mode.
module mux_arb_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  input  logic               mode,
  output logic               any,
  output logic [SEL_W-1:0]   win
);

  logic [SEL_W-1:0] idx_s;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    any   = |req;
    win   = 2'd0;
    idx_s = 2'd0;
    if (mode) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx_s = last + SEL_W'(k);
        if (req[idx_s]) begin
          win = idx_s;
        end else begin
          win = win;
        end
      end
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req[i]) begin
          win = SEL_W'(i);
        end else begin
          win = win;
        end
      end
    end
  end

endmodule

// File: rtl/mux_4to1_rr_arbiter.sv
// Arbiter/sequencer in front of a shared 4:1 mux: fixed or round-robin pick,
// bounded burst per grant, valid/ready handshake to one consumer.
module mux_4to1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req_in,
  input  logic [4*DATA_W-1:0]   d_in,
  input  logic                  prio_mode_in,
  input  logic                  ready_in,
  output logic [3:0]            gnt_out,
  output logic [1:0]            sel_out,
  output logic [DATA_W-1:0]     q_out,
  output logic                  valid_out,
  output logic                  busy_out
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_t           state_r, state_n;
  logic [3:0]       gnt_r, gnt_n;
  logic [1:0]       sel_r, sel_n;
  logic [3:0]       count_r, count_n;
  logic [1:0]       last_r, last_n;

  logic             xfer_s;
  logic             release_s;
  logic [3:0]       pick_req_s;
  logic [1:0]       pick_last_s;
  logic             pick_any_s;
  logic [1:0]       pick_win_s;

  assign valid_out = (state_r == ST_GRANT) && req_in[sel_r];
  assign busy_out  = (state_r == ST_GRANT);
  assign gnt_out   = gnt_r;
  assign sel_out   = sel_r;
  assign xfer_s    = valid_out && ready_in;

  // Release on a dropped request (no transfer possible) or on the burst-ending transfer.
  assign release_s = (state_r == ST_GRANT) &&
                     (!req_in[sel_r] || (xfer_s && (count_r + 4'd1 >= HOLD_LIM)));

  // One picker serves both the idle pick and the release pick; on release the
  // current holder is masked out and the scan starts just after it.
  assign pick_req_s  = (state_r == ST_GRANT) ? (req_in & ~onehot(sel_r)) : req_in;
  assign pick_last_s = (state_r == ST_GRANT) ? sel_r : last_r;

  mux_arb_pick u_pick (
    .req  (pick_req_s),
    .last (pick_last_s),
    .mode (prio_mode_in),
    .any  (pick_any_s),
    .win  (pick_win_s)
  );

  mux_4to1 #(.DATA_W(DATA_W)) u_mux (
    .d   (d_in),
    .sel (sel_r),
    .q   (q_out)
  );

  // Next-state and next-grant logic.
  always_comb begin
    state_n = state_r;
    gnt_n   = gnt_r;
    sel_n   = sel_r;
    count_n = count_r;
    last_n  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_n = ST_GRANT;
          gnt_n   = onehot(pick_win_s);
          sel_n   = pick_win_s;
          count_n = 4'd0;
        end else begin
          state_n = ST_IDLE;
          gnt_n   = 4'b0000;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          last_n  = sel_r;
          count_n = 4'd0;
          if (pick_any_s) begin
            state_n = ST_GRANT;
            gnt_n   = onehot(pick_win_s);
            sel_n   = pick_win_s;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = 4'b0000;
          end
        end else if (xfer_s) begin
          if (count_r < HOLD_LIM) begin
            count_n = count_r + 4'd1;
          end else begin
            count_n = count_r;
          end
        end else begin
          count_n = count_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = 4'b0000;
        sel_n   = 2'd0;
        count_n = 4'd0;
      end
    endcase
  end

  // Arbiter state registers; last_r resets to 3 so round-robin starts at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      gnt_r   <= 4'b0000;
      sel_r   <= 2'd0;
      count_r <= 4'd0;
      last_r  <= 2'd3;
    end else begin
      state_r <= state_n;
      gnt_r   <= gnt_n;
      sel_r   <= sel_n;
      count_r <= count_n;
      last_r  <= last_n;
    end
  end

endmodule
